// File: rtl/pos_packet_tx.sv
// pos_packet_tx: frames NCH position channels into a UART byte stream.
// Optional trailing XOR checksum byte when PKT_CHECKSUM_EN is defined.
module pos_packet_tx #(
   parameter int          NCH        = 2,
   parameter int          DW         = 10,
   parameter int          SYNC_LEN   = 3,
   parameter logic [7:0]  SYNC_BYTE  = 8'hFF,
   parameter int          GAP_CYCLES = 16,
   parameter int          TIMEOUT    = 40000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [NCH*DW-1:0] ch_data_in,
   input  logic              tx_done,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   output logic              frame_active,
   output logic [15:0]       frame_count,
   output logic              err_timeout
);

`ifdef PKT_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif
   localparam int L  = SYNC_LEN + 2 * NCH + CSUM;
   localparam int BW = $clog2(L);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     idx_q, idx_d;
   logic [TW-1:0]     to_q, to_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [NCH*DW-1:0] snap_q, snap_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              start_q, start_d;
   logic              act_q, act_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        byte_v;
   logic [7:0]        csum;
   int                k;

   function automatic logic [7:0] hi_byte(input logic [DW-1:0] v);
      return 8'(v >> 8);
   endfunction

   // XOR of all payload bytes taken from the frame snapshot
   always_comb begin
      csum = '0;
      for (int i = 0; i < NCH; i++) begin
         csum = csum ^ snap_q[i*DW +: 8]
                     ^ hi_byte(snap_q[i*DW +: DW]);
      end
   end

   // byte value for the index about to be sent
   always_comb begin
      byte_v = SYNC_BYTE;
      k      = int'(idx_d) - SYNC_LEN;
      for (int i = 0; i < NCH; i++) begin
         if (k == 2 * i)
            byte_v = snap_q[i*DW +: 8];
         else if (k == 2 * i + 1)
            byte_v = hi_byte(snap_q[i*DW +: DW]);
      end
      if (CSUM != 0 && k == 2 * NCH)
         byte_v = csum;
   end

   // next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      to_d    = to_q;
      gap_d   = gap_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable)
               state_d = S_LOAD;
         end
         S_LOAD: begin
            snap_d  = ch_data_in;
            idx_d   = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            to_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               if (idx_q == BW'(L - 1)) begin
                  cnt_d   = cnt_q + 16'd1;
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  idx_d   = idx_q + BW'(1);
                  state_d = S_SEND;
               end
            end else if (to_q == TW'(TIMEOUT - 2)) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = S_GAP;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      start_d = (state_d == S_SEND);
      data_d  = start_d ? byte_v : data_q;
      act_d   = (state_d == S_LOAD) ||
                (state_d == S_SEND) ||
                (state_d == S_WAIT);
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         to_q    <= '0;
         gap_q   <= '0;
         snap_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         act_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         to_q    <= to_d;
         gap_q   <= gap_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         start_q <= start_d;
         act_q   <= act_d;
         data_q  <= data_d;
      end
   end

   assign tx_data      = data_q;
   assign tx_start     = start_q;
   assign frame_active = act_q;
   assign frame_count  = cnt_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_pos_packet_tx.sv
// tb_pos_packet_tx: randomized frames against a byte-list reference model.
// Covers latency, mid-frame data change, enable drop, timeout and reset.
module tb_pos_packet_tx;
   localparam int NCH = 2;
   localparam int DW = 10;
   localparam int SYNC_LEN = 3;
   localparam int GAP = 16;
   localparam int TMO = 100;
`ifdef PKT_CHECKSUM_EN
   localparam int L = SYNC_LEN + 2 * NCH + 1;
`else
   localparam int L = SYNC_LEN + 2 * NCH;
`endif

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic [NCH*DW-1:0] ch_data_in;
   logic tx_done = 1'b0;
   logic [7:0] tx_data;
   logic tx_start;
   logic frame_active;
   logic [15:0] frame_count;
   logic err_timeout;

   pos_packet_tx #(
      .NCH(NCH), .DW(DW), .SYNC_LEN(SYNC_LEN),
      .SYNC_BYTE(8'hFF), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .ch_data_in(ch_data_in), .tx_done(tx_done),
      .tx_data(tx_data), .tx_start(tx_start),
      .frame_active(frame_active), .frame_count(frame_count),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: logs bytes, answers tx_done uart_delay clocks later
   logic [7:0] got[$];
   int scyc[$];
   int err_cyc = -1;
   int err_n = 0;
   int uart_delay = 5;
   bit spur = 1'b0;
   int mute_idx = -1;
   bit pend = 1'b0;
   int dcnt = 0;

   always @(negedge clk) begin
      tx_done = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            dcnt--;
            if (dcnt == 0) begin
               tx_done = 1'b1;
               pend = 1'b0;
            end
         end
         if (tx_start) begin
            got.push_back(tx_data);
            scyc.push_back(cyc);
            if (got.size() - 1 != mute_idx) begin
               pend = 1'b1;
               dcnt = uart_delay;
            end
            if (spur) tx_done = 1'b1;
         end
         if (err_timeout) begin
            err_cyc = cyc;
            err_n++;
         end
      end
   end

   int npass = 0;
   int nchk = 0;
   int vals[NCH];
   int newv[NCH];
   int exp_q[$];
   int fc = 0;

   task automatic chk(input string tag, input int act, input int exp_v);
      nchk++;
      if (act == exp_v) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ch(input int v[NCH]);
      for (int i = 0; i < NCH; i++) ch_data_in[i*DW +: DW] = DW'(v[i]);
   endtask

   task automatic wait_starts(input int n);
      int t = 0;
      while (got.size() < n && t < 3000) begin
         tick();
         t++;
      end
      chk("start_wait", int'(got.size() >= n), 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (frame_active && t < 3000) begin
         tick();
         t++;
      end
      chk("idle_wait", int'(frame_active), 0);
   endtask

   // expected frame: sync bytes, lo/hi per channel, optional XOR
   task automatic build_exp(input int v[NCH]);
      int cs = 0;
      exp_q = {};
      for (int s = 0; s < SYNC_LEN; s++) exp_q.push_back(8'hFF);
      for (int c = 0; c < NCH; c++) begin
         exp_q.push_back(v[c] % 256);
         exp_q.push_back(v[c] / 256);
         cs = cs ^ (v[c] % 256) ^ (v[c] / 256);
      end
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   task automatic check_frame(input int base, input int v[NCH]);
      build_exp(v);
      chk("frame_len", got.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < got.size())
            chk($sformatf("byte%0d", i), int'(got[base + i]), exp_q[i]);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_data"}, int'(tx_data), 0);
      chk({tag, "_start"}, int'(tx_start), 0);
      chk({tag, "_active"}, int'(frame_active), 0);
      chk({tag, "_count"}, int'(frame_count), 0);
      chk({tag, "_err"}, int'(err_timeout), 0);
   endtask

   initial begin
      int base, en_cyc, n, ec0, t;
      rst = 1'b1;
      enable = 1'b0;
      ch_data_in = '0;
      repeat (3) tick();
      check_reset("rst");
      rst = 1'b0;
      tick();

      // directed frame, enable dropped during byte 2
      vals[0] = 'h2A5;
      vals[1] = 'h13C;
      set_ch(vals);
      base = got.size();
      enable = 1'b1;
      en_cyc = cyc;
      wait_starts(base + 2);
      enable = 1'b0;
      wait_starts(base + L);
      wait_idle();
      check_frame(base, vals);
      fc++;
      chk("latency", scyc[base] - en_cyc, 2);
      chk("done2start", scyc[base + 1] - scyc[base], 6);
      chk("count1", int'(frame_count), fc);
      n = got.size();
      repeat (200) tick();
      chk("quiet", got.size(), n);
      chk("quiet_active", int'(frame_active), 0);

      // random frames; ch_data_in changes after LOAD
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < NCH; i++)
            newv[i] = $urandom_range(0, (1 << DW) - 1);
         if (f == 0) newv[0] = 'h3FF;
         base = got.size();
         uart_delay = $urandom_range(1, 8);
         spur = 1'($urandom_range(0, 1));
         enable = 1'b1;
         wait_starts(base + 1);
         set_ch(newv);
         enable = 1'b0;
         wait_starts(base + L);
         wait_idle();
         check_frame(base, vals);
         fc++;
         chk("count", int'(frame_count), fc);
         vals = newv;
         repeat (GAP + 2) tick();
      end

      // UART stalls on the 4th byte
      uart_delay = 5;
      spur = 1'b0;
      base = got.size();
      mute_idx = base + 3;
      ec0 = err_n;
      enable = 1'b1;
      wait_starts(base + 4);
      t = 0;
      while (err_n == ec0 && t < 300) begin
         tick();
         t++;
      end
      chk("tmo_seen", int'(err_n > ec0), 1);
      chk("tmo_lat", err_cyc - scyc[base + 3], TMO);
      chk("tmo_active", int'(frame_active), 0);
      chk("tmo_count", int'(frame_count), fc);
      wait_starts(base + 5);
      mute_idx = -1;
      enable = 1'b0;
      chk("restart_byte", int'(got[base + 4]), 'hFF);
      chk("restart_lat", scyc[base + 4] - err_cyc, GAP + 2);
      wait_starts(base + 4 + L);
      wait_idle();
      check_frame(base + 4, vals);
      fc++;
      chk("tmo_pulses", err_n - ec0, 1);
      chk("count_after_tmo", int'(frame_count), fc);
      repeat (GAP + 2) tick();

      // reset while waiting on byte 5
      base = got.size();
      mute_idx = base + 4;
      enable = 1'b1;
      wait_starts(base + 5);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_reset("midrst");
      rst = 1'b0;
      mute_idx = -1;
      base = got.size();
      wait_starts(base + 1);
      enable = 1'b0;
      wait_starts(base + L);
      wait_idle();
      check_frame(base, vals);
      chk("count_after_rst", int'(frame_count), 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule

// File: doc/pos_packet_tx.md
Name: pos_packet_tx

Overview:
- Parametrised UART packet framer that serialises NCH position channels into a byte stream for the board-to-board link.
- Frame format: SYNC_LEN sync bytes, then for each channel a low byte and a zero-extended high byte.
- Sits between the game-state logic (tank/projectile coordinates) and the UART transmitter.
- Paces bytes on the UART's tx_done handshake rather than a fixed delay, snapshots all channels atomically per frame, and recovers from a stalled UART by timeout.

Parameters:
- NCH, 2, number of position channels per frame (1..8).
- DW, 10, bits per channel (9..16); high byte carries bits DW-1:8, zero-extended.
- SYNC_LEN, 3, number of sync bytes per frame (1..7).
- SYNC_BYTE, 8'hFF, sync byte value.
- GAP_CYCLES, 16, idle clocks between frames (>=1).
- TIMEOUT, 40000, max clocks to wait for tx_done per byte (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when high, frames are sent back-to-back (separated by the gap).
- ch_data_in  in  NCH*DW  channel i occupies bits [i*DW +: DW].
- tx_done  in  1  one-cycle pulse from the UART when the current byte has finished.
- tx_data  out  8  byte to the UART; valid while tx_start is high, held until the next tx_start.
- tx_start  out  1  one-cycle start pulse to the UART.
- frame_active  out  1  high from LOAD through the last byte's tx_done.
- frame_count  out  16  completed frames, wraps 16'hFFFF -> 0.
- err_timeout  out  1  one-cycle pulse when a byte times out.

Behaviour:
- Reset values: tx_data=0, tx_start=0, frame_active=0, frame_count=0, err_timeout=0. State=IDLE; byte index, timeout counter, gap counter and snapshot all cleared.
- All outputs are registered.
- Frame length L = SYNC_LEN + 2*NCH (+1 when the checksum is compiled in).
- Byte index b in 0..L-1:
  - b < SYNC_LEN: SYNC_BYTE.
  - Otherwise k = b - SYNC_LEN, channel c = k/2.
  - k even: snapshot[c][7:0].
  - k odd: {zeros, snapshot[c][DW-1:8]}.
- States:
  - IDLE: enable high -> LOAD.
  - LOAD: capture all of ch_data_in into the snapshot; b=0; frame_active=1 -> SEND.
  - SEND: tx_start=1 for exactly this cycle; tx_data=byte(b); timeout counter cleared -> WAIT.
  - WAIT: tx_done sampled only in this state.
    - tx_done and b < L-1: b++ -> SEND.
    - tx_done and b = L-1: frame_count++, frame_active=0 -> GAP.
    - Timeout counter reaches TIMEOUT-1 without tx_done: err_timeout pulse, frame_active=0, frame not counted -> GAP.
  - GAP: count GAP_CYCLES clocks -> IDLE.
- Latency:
  - enable sampled high in IDLE -> tx_start high 2 clocks later.
  - tx_done -> next tx_start 1 clock later.
- Boundary conditions:
  - tx_done outside WAIT (including the same cycle as tx_start) is ignored.
  - enable dropping mid-frame does not abort: the current frame completes, then the block stays in IDLE.
  - ch_data_in changes mid-frame do not affect the frame in flight.
  - rst mid-frame returns everything to reset values on the next edge. No partial byte is re-sent.
  - If tx_done coincides with the timeout expiring, tx_done wins.
  - Timeout counter width is clog2(TIMEOUT+1).

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- Defined: one extra byte is appended after the last channel byte. Its value is the XOR of all payload bytes (sync bytes excluded), computed from the snapshot. L grows by 1.
- Undefined: no checksum byte; the frame ends after the last high byte.

Test Plan:
- NCH=2, DW=10, SYNC_LEN=3, X=0x2A5, Y=0x13C, UART model returns tx_done 5 clocks after each tx_start -> bytes FF FF FF A5 02 3C 01; frame_count=1.
- Same stimulus with PKT_CHECKSUM_EN -> 8th byte 0x9A.
- Change ch_data_in to X=0x3FF right after LOAD -> current frame still carries A5 02; next frame carries FF 03.
- Hold tx_done low after the 4th tx_start, TIMEOUT=100 -> err_timeout pulse 100 clocks after that tx_start; frame_count unchanged; after GAP_CYCLES a new frame restarts with FF.
- Deassert enable during byte 2 -> all 7 bytes sent, then no tx_start for at least 200 clocks; frame_active=0.
- Assert rst during WAIT on byte 5 -> next cycle all outputs at reset values; a new frame starts with SYNC_BYTE after enable.
